relu_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one `relu` activation unit among `N_REQ` producers (conv/PE output lanes) of the CNN accelerator. Accepts 16-bit signed samples through per-requester valid/ready handshakes and issues at most one sample per cycle into the 1-cycle-latency `relu`. Tags each sample with its source ID. Buffers results in a credit-managed output FIFO, because `relu` cannot stall, and presents them on a single valid/ready output toward the pooling/writeback stage.

---
 rtl/relu_ctrl_pkg.sv | 28 ++
 rtl/relu.sv | 38 +++
 rtl/relu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_relu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_ctrl_pkg.sv
// Purpose: shared widths, tag helper and FIFO entry type for the shared-relu sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ACT_W sample width, MAX_ID_W tag storage width, clog2(), res_entry_t {id, data}.
package relu_ctrl_pkg;

  localparam int ACT_W = 16;

  // Tag field width stored in each FIFO entry; requester IDs are zero-extended into it,
  // so any N_REQ up to 2**MAX_ID_W fits without changing the entry layout.
  localparam int MAX_ID_W = 8;

  // Ceiling log2, never below 1 so a tag/pointer always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [ACT_W-1:0]    data;
  } res_entry_t;

endpackage

// File: rtl/relu.sv
// Purpose: activation unit, out = max(0, in) on a 16-bit signed sample.
// Latency: 1 cycle from valid_in to valid_out.
// Backpressure: none; it cannot stall, the caller must have room for every result.
// Ports: clk, rst (sync, active-high), valid_in/in_data in, valid_out/out_data out.
module relu
  import relu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [ACT_W-1:0] in_data,
  output logic             valid_out,
  output logic [ACT_W-1:0] out_data
);

  logic             valid_d, valid_q;
  logic [ACT_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_in;
    // Negative two's-complement samples clamp to zero.
    data_d  = in_data[ACT_W-1] ? '0 : in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/relu_arbiter.sv
// Purpose: round-robin share of one relu among N_REQ producers, results tagged and queued.
// Latency: 2 cycles grant-to-out_valid when the output FIFO is empty.
// Backpressure: grants only while credit (free FIFO slots minus in-flight) is nonzero.
// Ports: clk, rst_n; en_mask/req_valid/req_data in, req_ready out (one-hot grant);
//        out_valid/out_data/out_id out with out_ready in; busy out.
module relu_arbiter
  import relu_ctrl_pkg::*;
#(
  parameter int  N_REQ      = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       en_mask,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*ACT_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACT_W-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   busy
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0]  rr_ptr_d,   rr_ptr_q;
  logic             inflight_d, inflight_q;
  logic [ID_W-1:0]  id_d,       id_q;
  logic [PTR_W-1:0] wr_ptr_d,   wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d,   rd_ptr_q;
  logic [CNT_W-1:0] count_d,    count_q;
  logic             out_valid_d, out_valid_q;
  logic             busy_d,     busy_q;
  res_entry_t       mem_q [FIFO_DEPTH];
  res_entry_t       wr_entry_d;
  res_entry_t       head;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] elig;
  logic             has_credit;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  int               scan_idx;
  logic [ACT_W-1:0] relu_in_dat;
  logic             relu_vld_out;
  logic [ACT_W-1:0] relu_out_dat;
  logic             push;
  logic             pop;

  always_comb begin
    elig       = req_valid & en_mask;
    // Credit uses registered occupancy only: a pop this cycle frees its slot next cycle.
    has_credit = (int'(count_q) + int'(inflight_q)) < FIFO_DEPTH;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    scan_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(scan_idx);
      end
    end
    // rst_n gates the grant so req_ready drops the moment reset asserts,
    // not on the next edge.
    if (!has_credit || !rst_n) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
    relu_in_dat = req_data[ACT_W*int'(grant_idx) +: ACT_W];
  end

  relu u_relu (
    .clk      (clk),
    .rst      (~rst_n),
    .valid_in (grant_vld),
    .in_data  (relu_in_dat),
    .valid_out(relu_vld_out),
    .out_data (relu_out_dat)
  );

  // ---------------------------------------------------------------------------
  // Next-state: pointer, in-flight tag, FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = grant_vld;
    id_d       = grant_vld ? grant_idx : id_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // relu cannot stall, so every result is pushed; credit guarantees room.
    push       = relu_vld_out;
    pop        = out_valid_q & out_ready;

    wr_entry_d.id   = MAX_ID_W'(id_q);
    wr_entry_d.data = relu_out_dat;

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    out_valid_d = (count_d != '0);
    busy_d      = inflight_d | (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      id_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      id_q        <= id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Storage is cleared on reset so the head (and thus out_data/out_id) reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken from registers, nothing combinational from out_ready.
  // ---------------------------------------------------------------------------
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign out_data  = head.data;
  assign out_id    = head.id[ID_W-1:0];
  assign busy      = busy_q;

  // A push into a full FIFO means the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(FIFO_DEPTH))));

  // Tags are zero-extended on write, so the spare upper tag bits must stay clear.
  a_tag_range: assert property (@(posedge clk) disable iff (!rst_n)
    head.id == MAX_ID_W'(out_id));

endmodule

// File: tb/tb_relu_arbiter.sv
module tb_relu_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  en_mask;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_id;
  logic        busy;

  always #5 clk = ~clk;

  relu_arbiter #(.N_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_mask  (en_mask),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: round-robin pointer, one pending relu sample, result queue.
  int          m_rr;
  bit          pend_v;
  int          pend_id;
  logic [15:0] pend_dat;
  int          q_id[$];
  logic [15:0] q_dat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] act_fn(input logic [15:0] x);
    return ($signed(x) < 0) ? 16'h0000 : x;
  endfunction

  function automatic logic [63:0] lane(input int i, input logic [15:0] v);
    return 64'(v) << (16 * i);
  endfunction

  function automatic int exp_grant();
    int free;
    free = DEPTH - q_dat.size() - (pend_v ? 1 : 0);
    if (free <= 0) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i] && en_mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_rr   = 0;
    pend_v = 0;
    q_id.delete();
    q_dat.delete();
  endtask

  // Called at posedge+1: apply inputs and let combinational grant settle.
  task automatic drive(input logic [3:0] en, input logic [3:0] vld,
                       input logic [63:0] dat, input logic ordy);
    en_mask   = en;
    req_valid = vld;
    req_data  = dat;
    out_ready = ordy;
    #1;
  endtask

  // Compare DUT against the model for this cycle, advance model, move to next posedge+1.
  task automatic step();
    int g;
    g = exp_grant();
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("out_valid", out_valid, q_dat.size() != 0);
    if (q_dat.size() != 0) begin
      chk("out_data", out_data, q_dat[0]);
      chk("out_id", out_id, q_id[0]);
    end
    chk("busy", busy, pend_v || (q_dat.size() != 0));
    if (q_dat.size() != 0 && out_ready) begin
      void'(q_dat.pop_front());
      void'(q_id.pop_front());
    end
    if (pend_v) begin
      q_dat.push_back(act_fn(pend_dat));
      q_id.push_back(pend_id);
    end
    pend_v = (g >= 0);
    if (g >= 0) begin
      pend_id  = g;
      pend_dat = req_data[g*16 +: 16];
      m_rr     = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(4'hF, 4'h0, 64'h0, 1'b1);
      step();
    end
  endtask

  task automatic reset_now();
    en_mask   = 4'hF;
    req_valid = 4'hF;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bv[4];
    logic [15:0] bx[4];
    logic [3:0]  prev;
    int          cnt[N];
    int          grants;

    bv = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
    bx = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
    rst_n = 1'b0;
    req_data = 64'h0;
    @(posedge clk);
    #1;
    reset_now();

    // Single sample from requester 2: -5 then 300.
    drive(4'hF, 4'b0100, lane(2, 16'hFFFB), 1'b1);
    chk("single_grant", req_ready, 4'b0100);
    step();
    drive(4'hF, 4'h0, 64'h0, 1'b1);
    chk("single_lat1", out_valid, 0);
    step();
    drive(4'hF, 4'h0, 64'h0, 1'b1);
    chk("single_lat2_valid", out_valid, 1);
    chk("single_neg_data", out_data, 0);
    chk("single_neg_id", out_id, 2);
    step();
    drive(4'hF, 4'b0100, lane(2, 16'd300), 1'b1);
    step();
    idle(1);
    drive(4'hF, 4'h0, 64'h0, 1'b1);
    chk("single_pos_data", out_data, 300);
    chk("single_pos_id", out_id, 2);
    step();
    idle(2);

    // All four valid, full drain rate: strict 0,1,2,3 rotation, 1 result/cycle.
    reset_now();
    for (int j = 0; j < N; j++) cnt[j] = 0;
    for (int i = 0; i < 16; i++) begin
      drive(4'hF, 4'hF, {$urandom, $urandom}, 1'b1);
      chk("rr_order", req_ready, 4'b0001 << (i % 4));
      if (i >= 2) chk("rr_tput", out_valid, 1);
      for (int j = 0; j < N; j++) if (req_ready[j]) cnt[j]++;
      step();
    end
    for (int j = 0; j < N; j++) chk("rr_lane_cnt", cnt[j], 4);
    idle(4);

    // Backpressure: exactly DEPTH grants, then stall; drain and recover credit.
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 4'hF, {$urandom, $urandom}, 1'b0);
      if (req_ready != 4'h0) grants++;
      step();
    end
    chk("bp_grants", grants, 4);
    drive(4'hF, 4'hF, 64'h0, 1'b0);
    chk("bp_stalled", req_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    step();
    idle(6);
    drive(4'hF, 4'h0, 64'h0, 1'b1);
    chk("bp_idle_busy", busy, 0);
    step();
    drive(4'hF, 4'hF, {$urandom, $urandom}, 1'b1);
    chk("bp_credit", req_ready != 4'h0, 1);
    step();
    idle(4);

    // Mask 1010: alternate 1 and 3; then only 1.
    prev = 4'h0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1010, 4'hF, {$urandom, $urandom}, 1'b1);
      if (i == 0) chk("mask_first", (req_ready == 4'b0010) || (req_ready == 4'b1000), 1);
      else chk("mask_alt", req_ready, (prev == 4'b0010) ? 4'b1000 : 4'b0010);
      prev = req_ready;
      step();
    end
    for (int i = 0; i < 6; i++) begin
      drive(4'b0010, 4'hF, {$urandom, $urandom}, 1'b1);
      chk("mask_only1", req_ready, 4'b0010);
      step();
    end
    idle(4);

    // Boundary values through requester 0.
    for (int i = 0; i < 6; i++) begin
      drive(4'b0001, (i < 4) ? 4'b0001 : 4'b0000, (i < 4) ? lane(0, bv[i]) : 64'h0, 1'b1);
      if (i >= 2) begin
        chk("bnd_valid", out_valid, 1);
        chk("bnd_data", out_data, bx[i-2]);
        chk("bnd_id", out_id, 0);
      end
      step();
    end
    idle(3);

    // Randomised traffic with stall-heavy and flowing segments.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] en;
      logic       ordy;
      en   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      ordy = (((i / 100) % 3) == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      drive(en, 4'($urandom), {$urandom, $urandom}, ordy);
      step();
    end
    idle(8);

    // Reset with one sample in flight and three queued.
    reset_now();
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 4'hF, {$urandom, $urandom}, 1'b0);
      step();
    end
    drive(4'hF, 4'h0, 64'h0, 1'b0);
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_valid", out_valid, 1);
    reset_now();
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 4'h0, 64'h0, 1'b1);
      chk("mid_no_stale", out_valid, 0);
      step();
    end
    drive(4'hF, 4'hF, {$urandom, $urandom}, 1'b1);
    chk("mid_first_grant", req_ready, 4'b0001);
    step();
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
